// File: rtl/rr_encoder_32x5.sv
`default_nettype none
// ============================================================================
// Module      : rr_encoder_32x5
// Description : Registered 32-to-5 request encoder with a valid/ready output
//               slot. Selects one asserted request line per free cycle, using
//               either fixed priority (lowest index wins) or round-robin
//               priority driven by an internal rotating pointer. GRANT is the
//               one-hot expansion of IDX, so it matches what a 5x32 line
//               decoder produces from IDX.
// Ports       : CLK    - clock, rising-edge active
//               RESET  - synchronous active-high reset
//               REQ    - level request lines, bit i = requester i
//               MODE   - 0 = fixed priority, 1 = round-robin
//               READY  - consumer accepts IDX when READY=1 and VALID=1
//               VALID  - IDX/GRANT hold a selected request
//               IDX    - encoded index of the selected request
//               GRANT  - one-hot of IDX while VALID=1, zero otherwise
// Revision    : 1.0 - initial release
// ============================================================================
module rr_encoder_32x5 #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 5
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] REQ,
   input  logic             MODE,
   input  logic             READY,
   output logic             VALID,
   output logic [IDX_W-1:0] IDX,
   output logic [WIDTH-1:0] GRANT
);

   logic               valid_q, valid_d;
   logic [IDX_W-1:0]   idx_q,   idx_d;
   logic [WIDTH-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]   ptr_q,   ptr_d;

   logic               slot_free;
   logic [IDX_W-1:0]   fix_idx;
   logic [2*WIDTH-1:0] req_dbl;
   logic [WIDTH-1:0]   req_rot;
   logic [IDX_W-1:0]   rr_off;
   logic [IDX_W-1:0]   rr_idx;
   logic [IDX_W-1:0]   sel;

   // The slot can take a new selection when empty or when the held entry is
   // being transferred this cycle.
   assign slot_free = ~valid_q | READY;

   always_comb begin
      // Fixed priority: scan from the top so the lowest set bit wins.
      fix_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (REQ[i]) fix_idx = IDX_W'(i);
      end

      // Round-robin: rotate the request vector so that bit 0 of req_rot is
      // REQ[ptr_q]; the lowest set bit of the rotated vector is the offset
      // from the pointer. WIDTH is a power of two, so the IDX_W-bit add
      // wraps modulo WIDTH for free.
      req_dbl = {REQ, REQ} >> ptr_q;
      req_rot = req_dbl[WIDTH-1:0];
      rr_off  = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req_rot[i]) rr_off = IDX_W'(i);
      end
      rr_idx = ptr_q + rr_off;

      sel = MODE ? rr_idx : fix_idx;

      // Defaults: hold everything (covers the backpressure case).
      valid_d = valid_q;
      idx_d   = idx_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;

      if (slot_free) begin
         if (|REQ) begin
            valid_d = 1'b1;
            idx_d   = sel;
            grant_d = WIDTH'(1) << sel;
            if (MODE) ptr_d = sel + IDX_W'(1);
         end else begin
            // IDX deliberately keeps its last value when the slot empties.
            valid_d = 1'b0;
            grant_d = '0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         idx_q   <= idx_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign VALID = valid_q;
   assign IDX   = idx_q;
   assign GRANT = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_encoder_32x5.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_encoder_32x5
// Description : Self-checking bench for rr_encoder_32x5. A behavioural model
//               of the selection rules tracks the expected outputs and is
//               compared against the DUT every cycle; directed scenarios add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_encoder_32x5;

   logic        CLK;
   logic        RESET;
   logic [31:0] REQ;
   logic        MODE;
   logic        READY;
   logic        VALID;
   logic [4:0]  IDX;
   logic [31:0] GRANT;

   int tests = 0;
   int fails = 0;

   rr_encoder_32x5 #(
      .WIDTH (32),
      .IDX_W (5)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .REQ   (REQ),
      .MODE  (MODE),
      .READY (READY),
      .VALID (VALID),
      .IDX   (IDX),
      .GRANT (GRANT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // 5x32 line decoder reference.
   function automatic logic [31:0] dec5(input logic [4:0] idx);
      logic [31:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_init  = 1'b0;
   bit          m_valid = 1'b0;
   int          m_idx   = 0;
   int          m_ptr   = 0;
   logic [31:0] m_grant = '0;

   always @(posedge CLK) begin
      int s;
      if (RESET) begin
         m_init  = 1'b1;
         m_valid = 1'b0;
         m_idx   = 0;
         m_ptr   = 0;
         m_grant = '0;
      end else if (!m_valid || READY) begin
         if (REQ == 32'h0) begin
            m_valid = 1'b0;
            m_grant = '0;
         end else begin
            s = -1;
            for (int k = 0; k < 32; k++) begin
               int j;
               j = MODE ? (m_ptr + k) % 32 : k;
               if (s < 0 && REQ[j]) s = j;
            end
            m_valid = 1'b1;
            m_idx   = s;
            m_grant = 32'h0;
            m_grant[s] = 1'b1;
            if (MODE) m_ptr = (s + 1) % 32;
         end
      end
   end

   always @(negedge CLK) begin
      if (m_init) begin
         chk("model_valid", {31'h0, VALID}, {31'h0, m_valid});
         chk("model_idx",   {27'h0, IDX},   32'(m_idx));
         chk("model_grant", GRANT, m_grant);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
   endtask

   initial begin
      RESET = 1'b1;
      REQ   = '0;
      MODE  = 1'b0;
      READY = 1'b0;
      tick();
      tick();
      chk("reset_valid", {31'h0, VALID}, 32'h0);
      chk("reset_idx",   {27'h0, IDX},   32'h0);
      chk("reset_grant", GRANT,          32'h0);
      RESET = 1'b0;

      // Reset in the middle of a held handshake.
      MODE = 1'b1; REQ = 32'h0000_0080; READY = 1'b0;
      tick();
      chk("midhs_idx7",   {27'h0, IDX}, 32'd7);
      chk("midhs_valid",  {31'h0, VALID}, 32'h1);
      tick();
      chk("midhs_hold7",  {27'h0, IDX}, 32'd7);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      chk("midhs_rst_valid", {31'h0, VALID}, 32'h0);
      chk("midhs_rst_idx",   {27'h0, IDX},   32'h0);
      chk("midhs_rst_grant", GRANT,          32'h0);
      // Pointer back at 0: bits 0 and 8 requested, 0 must win.
      REQ = 32'h0000_0101; READY = 1'b1;
      tick();
      chk("midhs_ptr0", {27'h0, IDX}, 32'd0);

      // Fixed priority.
      do_reset();
      MODE = 1'b0; REQ = 32'h8000_0014; READY = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("fixed_idx",   {27'h0, IDX},   32'd2);
         chk("fixed_grant", GRANT,          32'h4);
         chk("fixed_valid", {31'h0, VALID}, 32'h1);
      end

      // Round-robin wrap.
      do_reset();
      MODE = 1'b1; REQ = 32'h8000_0001; READY = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rr_wrap_idx", {27'h0, IDX}, (k % 2 == 0) ? 32'd0 : 32'd31);
      end

      // Backpressure hold.
      do_reset();
      MODE = 1'b1; REQ = 32'h0000_0030; READY = 1'b0;
      tick();
      chk("bp_first_idx", {27'h0, IDX}, 32'd4);
      REQ = 32'h0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("bp_hold_idx",   {27'h0, IDX},   32'd4);
         chk("bp_hold_valid", {31'h0, VALID}, 32'h1);
         chk("bp_hold_grant", GRANT,          32'h10);
      end
      READY = 1'b1;
      tick();
      chk("bp_drain_valid", {31'h0, VALID}, 32'h0);
      chk("bp_drain_grant", GRANT,          32'h0);
      chk("bp_drain_idx",   {27'h0, IDX},   32'd4);

      // MODE changed while held is ignored; the held entry stays put.
      do_reset();
      MODE = 1'b0; REQ = 32'h0000_0006; READY = 1'b0;
      tick();
      chk("mode_hold_idx", {27'h0, IDX}, 32'd1);
      MODE = 1'b1; REQ = 32'h0000_0004;
      tick();
      chk("mode_hold_idx2", {27'h0, IDX}, 32'd1);

      // Exhaustive encode/decode round-trip.
      do_reset();
      MODE = 1'b0; READY = 1'b1;
      for (int i = 0; i < 32; i++) begin
         REQ = 32'h1 << i;
         tick();
         chk("rt_idx",   {27'h0, IDX}, 32'(i));
         chk("rt_dec",   dec5(IDX),    GRANT);
      end

      // Empty, then refill with all requests in round-robin.
      REQ = 32'h0;
      tick();
      tick();
      chk("empty_valid", {31'h0, VALID}, 32'h0);
      chk("empty_grant", GRANT,          32'h0);
      do_reset();
      MODE = 1'b1; REQ = 32'hFFFF_FFFF; READY = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         chk("refill_idx",   {27'h0, IDX},   32'(k % 32));
         chk("refill_valid", {31'h0, VALID}, 32'h1);
      end

      REQ = 32'h0;
      tick();
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rr_encoder_32x5.md
Name: rr_encoder_32x5

Overview:
- Registered 32-to-5 encoder with valid/ready output handshake. It is the inverse of the 5x32 line decoder.
- Collapses a 32-bit request vector into a 5-bit index, using either fixed priority (lowest index wins) or round-robin priority.
- Drives register-file and write-select paths whose index is later expanded by the 5x32 decoder. The one-hot GRANT output equals the decoder output for IDX.

Parameters:
- WIDTH, 32, number of request lines; must be a power of two.
- IDX_W, 5, index width; must equal log2(WIDTH).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ  input  WIDTH  level request lines; bit i = requester i.
- MODE  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- READY  input  1  consumer accepts the current IDX when READY=1 and VALID=1.
- VALID  output  1  IDX/GRANT hold a selected request.
- IDX  output  IDX_W  encoded index of the selected request.
- GRANT  output  WIDTH  one-hot of IDX when VALID=1; all zeros when VALID=0.

Behaviour:
- Reset (RESET=1 at a rising edge): VALID=0, IDX=0, GRANT=0, internal pointer PTR=0. Reset overrides every other input, including an in-flight handshake.
- Output slot is "free" in a cycle when VALID=0, or when VALID=1 and READY=1 (transfer this cycle).
- Slot not free (VALID=1, READY=0): VALID, IDX, GRANT and PTR hold exactly. REQ is ignored, including deassertion of the held bit; a captured request is never dropped.
- Slot free and REQ all zero: VALID<=0 at the edge, GRANT<=0, IDX holds its last value, PTR unchanged.
- Slot free and REQ nonzero: select index s, then at the edge VALID<=1, IDX<=s, GRANT<=(1<<s). Latency is one cycle from REQ sampled to VALID.
- Fixed mode (MODE=0): s = lowest i with REQ[i]=1. PTR unchanged.
- Round-robin mode (MODE=1): s = first i with REQ[i]=1, searching PTR, PTR+1, ..., WIDTH-1, 0, ..., PTR-1. Then PTR<=(s+1) mod WIDTH, so 31 wraps to 0.
- MODE is sampled only at a selection edge. Changing it while the slot is held has no effect until the next selection.
- Back-to-back: with READY held at 1 and requests present, one new index is produced every cycle.
- The encoder does not clear requests. Requesters drop their REQ bit on seeing their GRANT bit with READY=1. A still-asserted bit may be reselected (fixed mode) or is revisited after the rotation (round-robin).
- Invariants:
  - GRANT has at most one bit set.
  - GRANT != 0 exactly when VALID=1.
  - GRANT[IDX]=1 whenever VALID=1.
- No combinational path from REQ, MODE or READY to any output. All outputs are flops.

Test Plan:
- Reset mid-handshake: VALID=1, IDX=7, READY=0, then RESET=1 for one edge -> VALID=0, IDX=0, GRANT=0; next selection in MODE=1 starts its search at index 0.
- Fixed priority: MODE=0, REQ=32'h8000_0014, READY=1 -> VALID=1, IDX=2, GRANT=32'h4 on every cycle while REQ is unchanged.
- Round-robin wrap: MODE=1, REQ=32'h8000_0001, READY=1 from reset -> IDX sequence 0, 31, 0, 31...; PTR wraps from 31 to 0.
- Backpressure hold: MODE=1, REQ=32'h0000_0030, READY=0 -> IDX=4 held with VALID=1 for 5 cycles, even after REQ changes to 0. On READY=1 with REQ=0 -> VALID=0 next edge.
- Exhaustive encode/decode round-trip: for each i in 0..31, REQ=1<<i, READY=1 -> IDX=i; feeding IDX to the 5x32 decoder returns exactly GRANT.
- Empty and refill: REQ=0 -> VALID stays 0 with GRANT=0. REQ=32'hFFFF_FFFF, MODE=1, READY=1 -> IDX runs 0..31 then repeats, one per cycle, with no gaps.
